// File: rtl/vpg_pkg.sv
// Shared types and constants for the video mode sequencer: mode codes, FSM
// states and the packed timing set handed to the VGA timing generator.
package vpg_pkg;

    localparam logic [3:0] MODE_1080P60 = 4'd0;
    localparam logic [3:0] MODE_720P60  = 4'd1;
    localparam logic [3:0] MODE_480P60  = 4'd2;

    typedef enum logic [2:0] {
        BLANK,
        PLL_CFG,
        WAIT_LOCK,
        LOAD,
        RUN
    } vpg_state_e;

    typedef struct packed {
        logic [11:0] h_total;
        logic [11:0] h_sync;
        logic [11:0] h_start;
        logic [11:0] h_end;
        logic [11:0] v_total;
        logic [11:0] v_sync;
        logic [11:0] v_start;
        logic [11:0] v_end;
    } vpg_timing_t;

    localparam vpg_timing_t TIMING_1080P60 = '{
        h_total: 12'd2199, h_sync: 12'd43, h_start: 12'd189, h_end: 12'd2109,
        v_total: 12'd1124, v_sync: 12'd4,  v_start: 12'd40,  v_end: 12'd1120
    };

    localparam vpg_timing_t TIMING_720P60 = '{
        h_total: 12'd1649, h_sync: 12'd39, h_start: 12'd257, h_end: 12'd1537,
        v_total: 12'd749,  v_sync: 12'd4,  v_start: 12'd24,  v_end: 12'd744
    };

    localparam vpg_timing_t TIMING_480P60 = '{
        h_total: 12'd799, h_sync: 12'd95, h_start: 12'd141, h_end: 12'd781,
        v_total: 12'd524, v_sync: 12'd1,  v_start: 12'd34,  v_end: 12'd514
    };

    // Unsupported codes fall back to 1080p60.
    function automatic logic [3:0] vpg_map_mode(input logic [3:0] m);
        if (m == MODE_720P60 || m == MODE_480P60) begin
            return m;
        end
        return MODE_1080P60;
    endfunction

endpackage

// File: rtl/vpg_timing_rom.sv
// Combinational mode code to timing set lookup; any code outside the table
// returns the 1080p60 set.
module vpg_timing_rom
    import vpg_pkg::*;
(
    input  logic [3:0]  mode,
    output vpg_timing_t timing
);

    always_comb begin
        case (mode)
            MODE_720P60: timing = TIMING_720P60;
            MODE_480P60: timing = TIMING_480P60;
            default:     timing = TIMING_1080P60;
        endcase
    end

endmodule

// File: rtl/vpg_mode_sequencer.sv
// Mode change sequencer: blank generator, reconfigure PLL, wait for stable lock,
// load timing, re-enable. Optional lock watchdog under VPG_LOCK_TIMEOUT_EN.
module vpg_mode_sequencer
    import vpg_pkg::*;
#(
    parameter int unsigned BLANK_CYCLES = 16,
    parameter int unsigned LOCK_STABLE  = 1024,
    parameter int unsigned LOCK_TIMEOUT = 2000000,
    parameter logic [3:0]  DEFAULT_MODE = 4'd0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  mode_req,
    input  logic        mode_req_valid,
    output logic        busy,
    output logic [3:0]  mode_active,
    output logic        pll_cfg_start,
    output logic [3:0]  pll_cfg_mode,
    input  logic        pll_cfg_done,
    input  logic        pll_locked,
    output logic        gen_enable,
    output logic [11:0] h_total,
    output logic [11:0] h_sync,
    output logic [11:0] h_start,
    output logic [11:0] h_end,
    output logic [11:0] v_total,
    output logic [11:0] v_sync,
    output logic [11:0] v_start,
    output logic [11:0] v_end,
    output logic        lock_err
);

    localparam int BW = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;
    localparam int LW = $clog2(LOCK_STABLE + 1);
    localparam logic [BW-1:0] BLANK_LAST = BW'(BLANK_CYCLES - 1);
    localparam logic [LW-1:0] LOCK_FULL  = LW'(LOCK_STABLE);
    localparam logic [3:0]    RST_MODE   = vpg_map_mode(DEFAULT_MODE);

    vpg_state_e    state_q, state_d;
    logic [BW-1:0] blank_cnt_q, blank_cnt_d;
    logic [LW-1:0] lock_cnt_q, lock_cnt_d;
    logic [3:0]    pending_q, pending_d;
    logic [3:0]    pnext_q, pnext_d;
    logic          pnext_vld_q, pnext_vld_d;
    logic [3:0]    active_q, active_d;
    vpg_timing_t   timing_q, timing_d;
    vpg_timing_t   rom_timing;
    logic          cfg_start_q, cfg_start_d;
    logic          gen_en_q, gen_en_d;
    logic          busy_q, busy_d;
    logic          lock_meta_q, lock_sync_q;
    logic          req_live, req_next;
    logic          timeout;

    vpg_timing_rom u_rom (
        .mode   (pending_q),
        .timing (rom_timing)
    );

    // Requests compare the raw code, so an unsupported code still triggers a
    // (re)configuration that lands on the fallback mode.
    assign req_live = mode_req_valid && (mode_req != active_q);
    assign req_next = pnext_vld_q && (pnext_q != active_q);

    always_comb begin
        state_d     = state_q;
        blank_cnt_d = '0;
        lock_cnt_d  = '0;
        pending_d   = pending_q;
        pnext_d     = pnext_q;
        pnext_vld_d = pnext_vld_q;
        active_d    = active_q;
        timing_d    = timing_q;

        if (state_q != RUN && mode_req_valid) begin
            pnext_d     = mode_req;
            pnext_vld_d = 1'b1;
        end

        case (state_q)
            BLANK: begin
                if (blank_cnt_q == BLANK_LAST) begin
                    state_d = PLL_CFG;
                end else begin
                    blank_cnt_d = blank_cnt_q + 1'b1;
                end
            end
            PLL_CFG: begin
                if (pll_cfg_done && !cfg_start_q) begin
                    state_d = WAIT_LOCK;
                end
            end
            WAIT_LOCK: begin
                if (lock_cnt_q == LOCK_FULL) begin
                    state_d = LOAD;
                end else if (timeout) begin
                    state_d = PLL_CFG;
                end else if (lock_sync_q) begin
                    lock_cnt_d = lock_cnt_q + 1'b1;
                end
            end
            LOAD: begin
                timing_d = rom_timing;
                active_d = pending_q;
                state_d  = RUN;
            end
            RUN: begin
                pnext_vld_d = 1'b0;
                if (req_live || req_next) begin
                    pending_d = vpg_map_mode(req_live ? mode_req : pnext_q);
                    state_d   = BLANK;
                end else if (!lock_sync_q) begin
                    state_d = WAIT_LOCK;
                end
            end
            default: state_d = BLANK;
        endcase

        // Start pulses on every entry into PLL_CFG, including watchdog retries.
        cfg_start_d = (state_d == PLL_CFG) && (state_q != PLL_CFG);
        gen_en_d    = (state_d == RUN);
        busy_d      = (state_d != RUN);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= BLANK;
            blank_cnt_q <= '0;
            lock_cnt_q  <= '0;
            pending_q   <= RST_MODE;
            pnext_q     <= '0;
            pnext_vld_q <= 1'b0;
            active_q    <= RST_MODE;
            timing_q    <= TIMING_1080P60;
            cfg_start_q <= 1'b0;
            gen_en_q    <= 1'b0;
            busy_q      <= 1'b1;
            lock_meta_q <= 1'b0;
            lock_sync_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            blank_cnt_q <= blank_cnt_d;
            lock_cnt_q  <= lock_cnt_d;
            pending_q   <= pending_d;
            pnext_q     <= pnext_d;
            pnext_vld_q <= pnext_vld_d;
            active_q    <= active_d;
            timing_q    <= timing_d;
            cfg_start_q <= cfg_start_d;
            gen_en_q    <= gen_en_d;
            busy_q      <= busy_d;
            lock_meta_q <= pll_locked;
            lock_sync_q <= lock_meta_q;
        end
    end

`ifdef VPG_LOCK_TIMEOUT_EN
    localparam int WW = $clog2(LOCK_TIMEOUT + 1);
    localparam logic [WW-1:0] WD_LAST = WW'(LOCK_TIMEOUT - 1);

    logic [WW-1:0] wd_q, wd_d;
    logic          lock_err_q, lock_err_d;

    // A lock that completes on the same cycle as the watchdog expiry wins.
    assign timeout = (state_q == WAIT_LOCK) && (wd_q == WD_LAST) &&
                     (lock_cnt_q != LOCK_FULL);

    always_comb begin
        wd_d       = '0;
        lock_err_d = lock_err_q;
        if (state_q == WAIT_LOCK && !timeout) begin
            wd_d = wd_q + 1'b1;
        end
        if (timeout) begin
            lock_err_d = 1'b1;
        end else if (state_q == RUN && (req_live || req_next)) begin
            lock_err_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wd_q       <= '0;
            lock_err_q <= 1'b0;
        end else begin
            wd_q       <= wd_d;
            lock_err_q <= lock_err_d;
        end
    end

    assign lock_err = lock_err_q;
`else
    assign timeout  = 1'b0;
    assign lock_err = 1'b0;
`endif

    assign busy          = busy_q;
    assign mode_active   = active_q;
    assign pll_cfg_start = cfg_start_q;
    assign pll_cfg_mode  = pending_q;
    assign gen_enable    = gen_en_q;
    assign h_total       = timing_q.h_total;
    assign h_sync        = timing_q.h_sync;
    assign h_start       = timing_q.h_start;
    assign h_end         = timing_q.h_end;
    assign v_total       = timing_q.v_total;
    assign v_sync        = timing_q.v_sync;
    assign v_start       = timing_q.v_start;
    assign v_end         = timing_q.v_end;

endmodule

// File: tb/tb_vpg_mode_sequencer.sv
// Directed bench for vpg_mode_sequencer: mode table sweep plus hand-written
// bring-up, ignore, queued-request, relock and (optional) watchdog sequences.
`timescale 1ns/1ps
module tb_vpg_mode_sequencer;

`ifdef VPG_LOCK_TIMEOUT_EN
    localparam int LS = 32;
`else
    localparam int LS = 1024;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  mode_req = 4'd0;
    logic        mode_req_valid = 1'b0;
    logic        pll_cfg_done;
    logic        pll_locked = 1'b1;
    logic        busy, pll_cfg_start, gen_enable, lock_err;
    logic [3:0]  mode_active, pll_cfg_mode;
    logic [11:0] h_total, h_sync, h_start, h_end;
    logic [11:0] v_total, v_sync, v_start, v_end;

    int         n_cmp = 0;
    int         n_bad = 0;
    int         n_start = 0;
    logic [3:0] last_cfg_mode = 4'd0;
    bit         saw_mode2 = 1'b0;

    typedef struct {
        logic [3:0] req;
        int         mode;
        int         ht, hs, hb, he, vt, vs, vb, ve;
    } vec_t;

    always #10 clk = ~clk;

    vpg_mode_sequencer #(
        .BLANK_CYCLES (16),
        .LOCK_STABLE  (LS),
        .LOCK_TIMEOUT (100),
        .DEFAULT_MODE (4'd0)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .mode_req       (mode_req),
        .mode_req_valid (mode_req_valid),
        .busy           (busy),
        .mode_active    (mode_active),
        .pll_cfg_start  (pll_cfg_start),
        .pll_cfg_mode   (pll_cfg_mode),
        .pll_cfg_done   (pll_cfg_done),
        .pll_locked     (pll_locked),
        .gen_enable     (gen_enable),
        .h_total        (h_total),
        .h_sync         (h_sync),
        .h_start        (h_start),
        .h_end          (h_end),
        .v_total        (v_total),
        .v_sync         (v_sync),
        .v_start        (v_start),
        .v_end          (v_end),
        .lock_err       (lock_err)
    );

    // PLL controller model: done pulse arrives 3 cycles after each start.
    initial begin
        pll_cfg_done = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (pll_cfg_start === 1'b1) begin
                n_start++;
                last_cfg_mode = pll_cfg_mode;
                if (pll_cfg_mode == 4'd2) saw_mode2 = 1'b1;
                repeat (3) begin @(posedge clk); #1; end
                pll_cfg_done = 1'b1;
                @(posedge clk); #1;
                pll_cfg_done = 1'b0;
            end
        end
    end

    initial begin
        #10ms;
        $display("FAIL global_timeout: simulation still running, required finish");
        $fatal(1, "global timeout");
    end

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    task automatic check_range(input string name, input int act, input int lo, input int hi);
        n_cmp++;
        if (act < lo || act > hi) begin
            n_bad++;
            $display("FAIL %s: got %0d, required %0d..%0d", name, act, lo, hi);
        end
    endtask

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic wait_gen(input string name, input int limit, output int cyc);
        cyc = 0;
        while (gen_enable !== 1'b1 && cyc < limit) begin
            step();
            cyc++;
        end
        check(name, int'(gen_enable === 1'b1), 1);
    endtask

    task automatic request(input logic [3:0] m);
        mode_req       = m;
        mode_req_valid = 1'b1;
        step();
        mode_req_valid = 1'b0;
    endtask

    task automatic do_reset(input string tag);
        reset = 1'b1;
        repeat (2) step();
        check({tag, "_busy"},      busy, 1);
        check({tag, "_gen"},       gen_enable, 0);
        check({tag, "_start"},     pll_cfg_start, 0);
        check({tag, "_cfg_mode"},  pll_cfg_mode, 0);
        check({tag, "_active"},    mode_active, 0);
        check({tag, "_lock_err"},  lock_err, 0);
        check({tag, "_h_total"},   h_total, 2199);
        check({tag, "_v_end"},     v_end, 1120);
        reset = 1'b0;
    endtask

    initial begin
        vec_t vecs[6];
        int   cyc;
        int   base;
        bit   flag;

        vecs[0] = '{4'd1,  1, 1649, 39, 257, 1537, 749,  4, 24, 744};
        vecs[1] = '{4'd2,  2, 799,  95, 141, 781,  524,  1, 34, 514};
        vecs[2] = '{4'd7,  0, 2199, 43, 189, 2109, 1124, 4, 40, 1120};
        vecs[3] = '{4'd2,  2, 799,  95, 141, 781,  524,  1, 34, 514};
        vecs[4] = '{4'd15, 0, 2199, 43, 189, 2109, 1124, 4, 40, 1120};
        vecs[5] = '{4'd2,  2, 799,  95, 141, 781,  524,  1, 34, 514};

        // Power-up bring-up of mode 0: 16 blank + 3 to done + 1 + 2 sync + LS + 1 LOAD.
        do_reset("rst");
        base = n_start;
        wait_gen("bringup_wait", 5000, cyc);
        check_range("bringup_latency", cyc, LS + 22, LS + 24);
        check("bringup_starts", n_start - base, 1);
        check("bringup_cfg_mode", last_cfg_mode, 0);
        check("bringup_busy", busy, 0);
        check("bringup_h_total", h_total, 2199);
        check("bringup_v_total", v_total, 1124);
        check("bringup_active", mode_active, 0);

        foreach (vecs[i]) begin
            base = n_start;
            request(vecs[i].req);
            check($sformatf("v%0d_busy", i), busy, 1);
            check($sformatf("v%0d_gen", i), gen_enable, 0);
            wait_gen($sformatf("v%0d_wait", i), 5000, cyc);
            check($sformatf("v%0d_starts", i), n_start - base, 1);
            check($sformatf("v%0d_cfg_mode", i), last_cfg_mode, vecs[i].mode);
            check($sformatf("v%0d_active", i), mode_active, vecs[i].mode);
            check($sformatf("v%0d_h_total", i), h_total, vecs[i].ht);
            check($sformatf("v%0d_h_sync", i), h_sync, vecs[i].hs);
            check($sformatf("v%0d_h_start", i), h_start, vecs[i].hb);
            check($sformatf("v%0d_h_end", i), h_end, vecs[i].he);
            check($sformatf("v%0d_v_total", i), v_total, vecs[i].vt);
            check($sformatf("v%0d_v_sync", i), v_sync, vecs[i].vs);
            check($sformatf("v%0d_v_start", i), v_start, vecs[i].vb);
            check($sformatf("v%0d_v_end", i), v_end, vecs[i].ve);
        end

        // Request equal to the active mode is ignored.
        base = n_start;
        flag = 1'b0;
        request(4'd2);
        repeat (40) begin
            if (busy !== 1'b0 || gen_enable !== 1'b1) flag = 1'b1;
            step();
        end
        check("same_req_disturbed", flag, 0);
        check("same_req_starts", n_start - base, 0);
        check("same_req_active", mode_active, 2);

        // Reset in the middle of a change aborts and restarts mode 0.
        request(4'd1);
        repeat (30) step();
        do_reset("midrst");
        base = n_start;
        saw_mode2 = 1'b0;
        cyc = 0;
        while (n_start == base && cyc < 100) begin step(); cyc++; end
        check("midrst_restart_start", n_start - base, 1);
        repeat (10) step();

        // Two requests while waiting for lock: only the last one survives.
        request(4'd2);
        request(4'd1);
        wait_gen("queued_first_wait", 5000, cyc);
        check("queued_first_active", mode_active, 0);
        check("queued_first_starts", n_start - base, 1);
        step();
        check("queued_one_run_gen", gen_enable, 0);
        check("queued_one_run_busy", busy, 1);
        wait_gen("queued_second_wait", 5000, cyc);
        check("queued_second_active", mode_active, 1);
        check("queued_second_cfg", last_cfg_mode, 1);
        check("queued_second_starts", n_start - base, 2);
        check("queued_no_mode2", saw_mode2, 0);
        check("queued_h_total", h_total, 1649);

        // Lock drop for 5 cycles: no reconfig, returns through LOAD with mode 1.
        base = n_start;
        flag = 1'b0;
        pll_locked = 1'b0;
        repeat (5) begin
            step();
            if (gen_enable === 1'b0) flag = 1'b1;
        end
        pll_locked = 1'b1;
        wait_gen("relock_wait", 5000, cyc);
        check("relock_gen_dropped", flag, 1);
        check_range("relock_latency", cyc, LS + 2, LS + 4);
        check("relock_starts", n_start - base, 0);
        check("relock_active", mode_active, 1);
        check("relock_h_total", h_total, 1649);
        check("relock_lock_err", lock_err, 0);

`ifdef VPG_LOCK_TIMEOUT_EN
        // Watchdog: lock held low until a retry, then unsupported code 3.
        base = n_start;
        pll_locked = 1'b0;
        request(4'd2);
        cyc = 0;
        while (n_start - base < 2 && cyc < 600) begin step(); cyc++; end
        check("wd_retry_starts", n_start - base, 2);
        check("wd_lock_err_set", lock_err, 1);
        check("wd_retry_cfg", last_cfg_mode, 2);
        pll_locked = 1'b1;
        request(4'd3);
        wait_gen("wd_first_wait", 5000, cyc);
        check("wd_first_active", mode_active, 2);
        step();
        check("wd_accept_busy", busy, 1);
        check("wd_lock_err_clear", lock_err, 0);
        wait_gen("wd_second_wait", 5000, cyc);
        check("wd_second_active", mode_active, 0);
        check("wd_second_cfg", last_cfg_mode, 0);
        check("wd_h_total", h_total, 2199);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
